// File: rtl/aludec_mdu.sv
// ALU control decoder with an iterative multiply/divide unit and the
// architectural HI/LO registers. Multiply is shift-add, divide is restoring
// shift-subtract, each taking one step per cycle over W cycles.
module aludec_mdu #(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         valid,
    input  logic [1:0]   aluop,
    input  logic [5:0]   func,
    input  logic [W-1:0] srca,
    input  logic [W-1:0] srcb,
    output logic [3:0]   alucontrol,
    output logic         illegal,
    output logic         stall,
    output logic         mdsel,
    output logic [W-1:0] mdres,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [W-1:0]     opb_q, opb_d;      // multiplicand or divisor magnitude
    logic             negq_q, negq_d;    // negate product / quotient
    logic             negr_q, negr_d;    // negate remainder
    logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;

    logic [3:0]   func_alu;
    logic         func_known;
    logic         is_r, is_mul, is_div, is_signed, md_go;
    logic         a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;
    logic [W:0]   mul_sum, div_shift;
    logic [2*W-1:0] mul_next, div_next, prod;
    logic         div_ge;
    logic [W-1:0] div_rem, quo_fix, rem_fix;

    assign is_r      = (aluop == 2'b10);
    assign is_mul    = (func == F_MULT) || (func == F_MULTU);
    assign is_div    = (func == F_DIV)  || (func == F_DIVU);
    assign is_signed = (func == F_MULT) || (func == F_DIV);
    assign md_go     = valid && is_r && (is_mul || is_div);

    assign illegal = valid && is_r && !func_known;
    assign mdsel   = valid && is_r && ((func == F_MFHI) || (func == F_MFLO));
    assign mdres   = !mdsel ? {W{1'b0}} : ((func == F_MFHI) ? hi_q : lo_q);
    assign stall   = ((state_q == S_IDLE) && md_go) || (state_q == S_MUL) || (state_q == S_DIV);
    assign hi      = hi_q;
    assign lo      = lo_q;

    // Signed operations iterate on magnitudes; the most negative value maps to 2**(W-1).
    assign a_neg = is_signed && srca[W-1];
    assign b_neg = is_signed && srcb[W-1];
    assign a_mag = a_neg ? -srca : srca;
    assign b_mag = b_neg ? -srcb : srcb;

    // One shift-add step: add multiplicand when the current multiplier bit is set.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[W-1:1]};
    assign prod     = negq_q ? -mul_next : mul_next;

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_rem   = div_ge ? W'(div_shift - {1'b0, opb_q}) : div_shift[W-1:0];
    assign div_next  = {div_rem, acc_q[W-2:0], div_ge};
    // A zero divisor yields all-ones quotient; the remainder is already the raw dividend.
    assign quo_fix   = (opb_q == {W{1'b0}}) ? {W{1'b1}}
                     : (negq_q ? -div_next[W-1:0] : div_next[W-1:0]);
    assign rem_fix   = negr_q ? -div_next[2*W-1:W] : div_next[2*W-1:W];

    // Function-field decode for R-type instructions.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        func_alu   = 4'b1111;
        func_known = 1'b1;
        case (func)
            6'b100000, 6'b100001: func_alu = 4'b0010;
            6'b100010, 6'b100011: func_alu = 4'b0110;
            6'b100100:            func_alu = 4'b0000;
            6'b100101:            func_alu = 4'b0001;
            6'b100110:            func_alu = 4'b0011;
            6'b100111:            func_alu = 4'b0100;
            6'b101010:            func_alu = 4'b0111;
            6'b101011:            func_alu = 4'b1000;
            6'b000000:            func_alu = 4'b1001;
            6'b000010:            func_alu = 4'b1010;
            6'b000011:            func_alu = 4'b1011;
            F_MULT, F_MULTU, F_DIV, F_DIVU,
            F_MFHI, F_MTHI, F_MFLO, F_MTLO: func_alu = 4'b0010;
            default:              func_known = 1'b0;
        endcase
    end

    // Main-decoder class selects the ALU operation.
    always_comb begin
        alucontrol = func_alu;
        case (aluop)
            2'b00:   alucontrol = 4'b0010;
            2'b01:   alucontrol = 4'b0110;
            2'b11:   alucontrol = 4'b0001;
            default: alucontrol = func_alu;
        endcase
    end

    // Next-state logic for the multiply/divide sequencer and HI/LO writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (md_go) begin
                    acc_d   = {{W{1'b0}}, a_mag};
                    opb_d   = b_mag;
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    cnt_d   = CNT_W'(W);
                    state_d = is_mul ? S_MUL : S_DIV;
                end else if (valid && is_r && (func == F_MTHI)) begin
                    hi_d = srca;
                end else if (valid && is_r && (func == F_MTLO)) begin
                    lo_d = srca;
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = prod[2*W-1:W];
                    lo_d    = prod[W-1:0];
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = rem_fix;
                    lo_d    = quo_fix;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: operand and HI/LO registers are cleared too, so an aborted operation leaves no residue.
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_aludec_mdu.sv
// Self-checking bench for aludec_mdu at W=32: decode tables, directed and
// randomized multiply/divide against an arithmetic reference, reset abort.
module tb_aludec_mdu;
    localparam int W = 32;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         reset_n, valid;
    logic [1:0]   aluop;
    logic [5:0]   func;
    logic [W-1:0] srca, srcb;
    logic [3:0]   alucontrol;
    logic         illegal, stall, mdsel;
    logic [W-1:0] mdres, hi, lo;

    int vectors = 0;
    int miscompares = 0;

    aludec_mdu #(.W(W), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .aluop(aluop), .func(func),
        .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .illegal(illegal),
        .stall(stall), .mdsel(mdsel), .mdres(mdres), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] ctl;
        logic       ill;
        logic       st;
        logic       ms;
    } dvec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference decode: returns {illegal-if-valid, alucontrol}.
    function automatic logic [4:0] dec_model(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return {1'b0, 4'b0010};
        if (op == 2'b01) return {1'b0, 4'b0110};
        if (op == 2'b11) return {1'b0, 4'b0001};
        case (f)
            6'h20, 6'h21: return {1'b0, 4'b0010};
            6'h22, 6'h23: return {1'b0, 4'b0110};
            6'h24: return {1'b0, 4'b0000};
            6'h25: return {1'b0, 4'b0001};
            6'h26: return {1'b0, 4'b0011};
            6'h27: return {1'b0, 4'b0100};
            6'h2a: return {1'b0, 4'b0111};
            6'h2b: return {1'b0, 4'b1000};
            6'h00: return {1'b0, 4'b1001};
            6'h02: return {1'b0, 4'b1010};
            6'h03: return {1'b0, 4'b1011};
            6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: return {1'b0, 4'b0010};
            default: return {1'b1, 4'b1111};
        endcase
    endfunction

    // Reference multiply/divide with plain 64-bit arithmetic: returns {hi, lo}.
    function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r = '0;
        if (f == F_MULT) begin
            r = 64'(sa * sb);
        end else if (f == F_MULTU) begin
            r = ua * ub;
        end else if (b == 32'd0) begin
            r = {a, 32'hFFFF_FFFF};
        end else if (f == F_DIV) begin
            sq = sa / sb;
            sr = sa % sb;
            r = {sr[31:0], sq[31:0]};
        end else begin
            uq = ua / ub;
            ur = ua % ub;
            r = {ur[31:0], uq[31:0]};
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        valid = v; aluop = op; func = f; srca = a; srcb = b;
    endtask

    task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        logic [63:0] exp;
        exp = md_model(f, a, b);
        @(posedge clk); #1;
        drive(1'b1, 2'b10, f, a, b);
        cyc = 0;
        @(negedge clk);
        while (stall === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check({name, " stall cycles"}, 64'(cyc), 64'd33);
        check({name, " hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
        check({name, " lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        check({name, " no restart after done"}, {63'd0, stall}, 64'd0);
    endtask

    initial begin
        dvec_t tbl [14];
        logic [5:0] md_funcs [4];
        logic [31:0] ra, rb;
        logic [4:0] dm;
        logic exp_st;

        tbl = '{
            '{1'b1, 2'b00, 6'h3f, 4'b0010, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b01, 6'h00, 4'b0110, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b11, 6'h18, 4'b0001, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b10, 6'h20, 4'b0010, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b10, 6'h2a, 4'b0111, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b10, 6'h2b, 4'b1000, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b10, 6'h03, 4'b1011, 1'b0, 1'b0, 1'b0},
            '{1'b1, 2'b10, 6'h18, 4'b0010, 1'b0, 1'b1, 1'b0},
            '{1'b1, 2'b10, 6'h10, 4'b0010, 1'b0, 1'b0, 1'b1},
            '{1'b1, 2'b10, 6'h3f, 4'b1111, 1'b1, 1'b0, 1'b0},
            '{1'b1, 2'b10, 6'h01, 4'b1111, 1'b1, 1'b0, 1'b0},
            '{1'b0, 2'b10, 6'h3f, 4'b1111, 1'b0, 1'b0, 1'b0},
            '{1'b0, 2'b10, 6'h1a, 4'b0010, 1'b0, 1'b0, 1'b0},
            '{1'b0, 2'b10, 6'h12, 4'b0010, 1'b0, 1'b0, 1'b0}
        };
        md_funcs = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

        // Reset state.
        reset_n = 1'b0;
        drive(1'b0, 2'b00, 6'h00, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall", {63'd0, stall}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset mdsel", {63'd0, mdsel}, 64'd0);

        // Table vectors, applied while reset holds the sequencer idle.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].f, 32'hDEAD_BEEF, 32'h1);
            #1;
            check($sformatf("tbl%0d ctl/ill/stall/mdsel/mdres", i),
                  {27'd0, alucontrol, illegal, stall, mdsel, mdres},
                  {27'd0, tbl[i].ctl, tbl[i].ill, tbl[i].st, tbl[i].ms, 32'd0});
        end

        // Full decode sweep against the reference decoder.
        for (int op = 0; op < 4; op++) begin
            for (int f = 0; f < 64; f++) begin
                drive(1'b1, 2'(op), 6'(f), 32'd0, 32'd0);
                #1;
                dm = dec_model(2'(op), 6'(f));
                exp_st = (op == 2) && (f >= 6'h18) && (f <= 6'h1b);
                check($sformatf("sweep op%0d f%02h", op, f),
                      {58'd0, alucontrol, illegal, stall}, {58'd0, dm[3:0], dm[4], exp_st});
            end
        end

        // Leave reset idle.
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(1'b0, 2'b00, 6'h00, 32'd0, 32'd0);

        // MTLO then MFLO; MTHI then MFHI; valid-low writes ignored.
        @(posedge clk); #1;
        drive(1'b1, 2'b10, F_MTLO, 32'h1234_ABCD, 32'd0);
        @(negedge clk);
        check("mtlo stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        drive(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
        @(negedge clk);
        check("mflo mdsel/stall", {62'd0, mdsel, stall}, {62'd0, 1'b1, 1'b0});
        check("mflo mdres", {32'd0, mdres}, {32'd0, 32'h1234_ABCD});
        @(posedge clk); #1;
        drive(1'b1, 2'b10, F_MTHI, 32'h0BAD_F00D, 32'd0);
        @(posedge clk); #1;
        drive(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
        @(negedge clk);
        check("mfhi mdres", {32'd0, mdres}, {32'd0, 32'h0BAD_F00D});
        @(posedge clk); #1;
        drive(1'b0, 2'b10, F_MTLO, 32'hFFFF_0000, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 2'b10, F_MFLO, 32'd0, 32'd0);
        @(negedge clk);
        check("invalid mtlo lo", {32'd0, lo}, {32'd0, 32'h1234_ABCD});
        check("invalid mflo mdsel/mdres", {31'd0, mdsel, mdres}, 64'd0);

        // Directed multiply/divide corners.
        run_md("mult -3*7", F_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        run_md("divu 100/7", F_DIVU, 32'd100, 32'd7);
        run_md("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2);
        run_md("divu 5/0", F_DIVU, 32'd5, 32'd0);
        run_md("div -7/0", F_DIV, 32'hFFFF_FFF9, 32'd0);
        run_md("mult min*min", F_MULT, 32'h8000_0000, 32'h8000_0000);
        run_md("div min/-1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("multu max*max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Randomized operations against the reference model.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 5)
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = rb >> $urandom_range(31, 0);
                default: ;
            endcase
            run_md($sformatf("rand%0d f%02h %08h,%08h", i, md_funcs[i % 4], ra, rb),
                   md_funcs[i % 4], ra, rb);
        end

        // Reset in the middle of a MULT aborts it and clears HI/LO.
        @(posedge clk); #1;
        drive(1'b1, 2'b10, F_MTLO, 32'h5555_AAAA, 32'd0);
        @(posedge clk); #1;
        drive(1'b1, 2'b10, F_MULT, 32'h0000_1234, 32'h0000_5678);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("mid-mult stall", {63'd0, stall}, 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort stall", {63'd0, stall}, 64'd0);
        check("abort hi/lo", {hi, lo}, 64'd0);
        drive(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
        #1;
        check("mfhi during reset", {31'd0, mdsel, mdres}, {31'd0, 1'b1, 32'd0});
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
        @(negedge clk);
        check("mflo after abort", {30'd0, stall, mdsel, mdres}, {30'd0, 1'b0, 1'b1, 32'd0});
        @(posedge clk); #1;
        valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/aludec_mdu.md
ALUDEC_MDU -- requirements
Module: aludec_mdu

Interface
REQ-001 Parameter W, default 32: datapath width of operands, HI and LO; W >= 4.
REQ-002 Parameter CNT_W, default 6: iteration counter width; SHALL satisfy 2**CNT_W > W.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 valid  input  1  instruction present in execute stage this cycle.
REQ-006 aluop  input  2  main-decoder class: 00 add, 01 sub, 10 R-type, 11 or-immediate.
REQ-007 func  input  6  R-type function field.
REQ-008 srca, srcb  input  W each  operands (rs, rt).
REQ-009 alucontrol  output  4  ALU operation select.
REQ-010 illegal  output  1  unsupported R-type func while valid.
REQ-011 stall  output  1  freeze PC and pipeline registers.
REQ-012 mdsel  output  1  writeback takes mdres instead of ALU result.
REQ-013 mdres  output  W  HI for MFHI, LO for MFLO, else 0.
REQ-014 hi, lo  output  W each  architectural HI/LO registers.

Function
REQ-015 alucontrol SHALL be combinational: aluop 00->0010, 01->0110, 11->0001.
REQ-016 aluop 10 SHALL decode func: 100000/100001->0010, 100010/100011->0110, 100100->0000, 100101->0001, 100110->0011, 100111->0100, 101010->0111, 101011->1000, 000000->1001, 000010->1010, 000011->1011.
REQ-017 aluop 10 with MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011 SHALL give alucontrol 0010 and illegal 0.
REQ-018 Any other func under aluop 10 SHALL give alucontrol 1111 and illegal = valid; no state change.
REQ-019 FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-020 IDLE, valid, mult/div func: latch magnitudes (signed ops) or raw values (unsigned), sign flags, counter = W; go MUL or DIV.
REQ-021 MUL: one shift-add step per cycle, counter decrements; at counter 1 go DONE.
REQ-022 DIV: one restoring shift-subtract step per cycle, counter decrements; at counter 1 go DONE.
REQ-023 Entry into DONE SHALL load {hi,lo}: product = 2W-bit result, negated if signs differ (MULT); LO = quotient, HI = remainder, quotient negated if signs differ, remainder takes sign of srca (DIV).
REQ-024 Divisor 0: still W iterations; result LO = all ones, HI = dividend (srca raw); no exception.
REQ-025 stall = (IDLE & valid & mult/div func) | MUL | DIV; total W+1 stall cycles, instruction retires in the DONE cycle.
REQ-026 DONE SHALL go IDLE next cycle unconditionally and SHALL NOT restart on the still-presented instruction.
REQ-027 MTHI/MTLO in IDLE with valid: hi/lo <= srca at clock edge, no stall; in DONE ignored.
REQ-028 MFHI/MFLO with valid: mdsel = 1, mdres = current hi/lo combinationally; mdsel 0 otherwise.
REQ-029 valid low SHALL suppress illegal, stall start, HI/LO writes and mdsel.
REQ-030 Signed operand -2**(W-1) SHALL use unsigned magnitude 2**(W-1); results wrap modulo 2**W per half.

Reset
REQ-031 reset_n low at an edge: state IDLE, counter 0, hi = lo = 0, internal operand registers 0; overrides all other events.
REQ-032 Reset mid-operation SHALL abort; stall SHALL read 0 from the next cycle unless a new mult/div is presented with valid.
REQ-033 Combinational outputs (alucontrol, illegal, mdsel, mdres) follow inputs during reset; mdres reflects zeroed HI/LO.

Verification (W=32)
REQ-034 Sweep all aluop/func combos, valid=1 -> alucontrol per REQ-015..018; illegal only on unlisted funcs.
REQ-035 MULT srca=FFFFFFFD, srcb=00000007 -> stall high 33 cycles, then hi=FFFFFFFF, lo=FFFFFFEB.
REQ-036 DIVU 100/7 -> lo=0000000E, hi=00000002; DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-037 DIVU 5/0 -> lo=FFFFFFFF, hi=00000005 after 33 stall cycles.
REQ-038 reset_n low at cycle 10 of MULT -> stall 0 next cycle, hi=lo=0, following MFLO returns 0.
REQ-039 MTLO 1234ABCD then MFLO next cycle -> mdsel=1, mdres=1234ABCD, no stall.
